// File: rtl/multicycle_control_fsm_if.sv
// Handshake and datapath-control bundle between the multi-cycle controller
// (master) and the instruction memory / register file / ALU datapath (slave).
interface multicycle_control_fsm_if #(
    parameter int OPC_W = 6,
    parameter int CNT_W = 16
);
    logic [OPC_W-1:0] opcode;
    logic             mem_ready;
    logic             zero;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic [1:0]       alu_op;
    logic             pc_write;
    logic             ir_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready, zero,
        output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, pc_write, ir_write, illegal, retired
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, pc_write, ir_write, illegal, retired
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// mem_ready handshake, illegal-opcode pulse and retired-instruction counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | read instruction memory; load IR and bump PC on mem_ready
// S_DECODE | classify latched opcode; unknown opcode pulses illegal
// S_EXEC   | ALU operation; BEQ resolves branch and retires here
// S_MEM    | data memory access held until mem_ready
// S_WB     | register-file write, retires
module multicycle_control_fsm #(
    parameter int               OPC_W    = 6,
    parameter logic [OPC_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OPC_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OPC_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OPC_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OPC_W-1:0] OP_ADDI  = 6'b001000,
    parameter int               CNT_W    = 16
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_control_fsm_if.master ctl
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             is_r, is_lw, is_sw, is_beq, is_addi, known;

    assign is_r    = (opc_q == OP_RTYPE);
    assign is_lw   = (opc_q == OP_LW);
    assign is_sw   = (opc_q == OP_SW);
    assign is_beq  = (opc_q == OP_BEQ);
    assign is_addi = (opc_q == OP_ADDI);
    assign known   = is_r | is_lw | is_sw | is_beq | is_addi;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (ctl.mem_ready) begin
                    opc_d   = ctl.opcode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = known ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (is_r || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (ctl.mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            retired_q <= retired_d;
        end
    end

    // ALU setup is held from EXECUTE through MEM/WB: there is no ALU-out
    // register, so the address / result must stay stable while it is consumed.
    always_comb begin
        ctl.reg_dst    = 1'b0;
        ctl.alu_src    = 1'b0;
        ctl.mem_to_reg = 1'b0;
        ctl.reg_write  = 1'b0;
        ctl.mem_read   = 1'b0;
        ctl.mem_write  = 1'b0;
        ctl.branch     = 1'b0;
        ctl.alu_op     = 2'b00;
        ctl.pc_write   = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.illegal    = 1'b0;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ctl.alu_op  = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
            ctl.alu_src = is_lw | is_sw | is_addi;
        end
        case (state_q)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                ctl.ir_write = ctl.mem_ready & ~reset;
                ctl.pc_write = ctl.mem_ready & ~reset;
            end
            S_DECODE: ctl.illegal = ~known;
            S_EXEC: begin
                ctl.branch   = is_beq & ctl.zero;
                ctl.pc_write = is_beq & ctl.zero;
            end
            S_MEM: begin
                ctl.mem_read  = is_lw;
                ctl.mem_write = is_sw;
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = is_r;
                ctl.mem_to_reg = is_lw;
            end
            default: ;
        endcase
    end

    assign ctl.retired = retired_q;
endmodule
